// File: rtl/bank_access_ctrl.sv
// Bank access controller: runs write/read bursts against a 4-bank synchronous line memory.
// Optional feature macro BANK_ACCESS_CTRL_BOUNDARY_CHECK_EN rejects bursts that would run past the top address.
module bank_access_ctrl #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LEN_W  = 3
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_bank,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              done,
  output logic              err,
  output logic [1:0]        Sel_Mem,
  output logic              Eneable,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] Data,
  output logic              WriteEneable,
  input  logic [DATA_W-1:0] LineData
);

  localparam int unsigned EXT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD_ISSUE, S_RD_CAP, S_RD_HOLD, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        bank_d;
  logic [ADDR_W-1:0] addr_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              over_c;

  // A burst is out of range when its last address carries past the top of the bank.
`ifdef BANK_ACCESS_CTRL_BOUNDARY_CHECK_EN
  logic [ADDR_W:0] end_addr;
  assign end_addr = EXT_W'(req_addr) + EXT_W'(req_len);
  assign over_c   = end_addr[ADDR_W];
`else
  assign over_c   = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= S_IDLE;
      Sel_Mem   <= '0;
      Address   <= '0;
      beat_q    <= '0;
      len_q     <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
      req_ready <= 1'b0;
      wr_ready  <= 1'b0;
    end else begin
      state_q   <= state_d;
      Sel_Mem   <= bank_d;
      Address   <= addr_d;
      beat_q    <= beat_d;
      len_q     <= len_d;
      if (state_q == S_RD_CAP) rd_data <= LineData;
      rd_valid  <= (state_d == S_RD_HOLD);
      done      <= (state_d == S_DONE) || (state_d == S_ERR);
      req_ready <= (state_d == S_IDLE);
      wr_ready  <= (state_d == S_WR);
    end
  end

`ifdef BANK_ACCESS_CTRL_BOUNDARY_CHECK_EN
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) err <= 1'b0;
    else       err <= (state_d == S_ERR);
  end
`else
  assign err = 1'b0;
`endif

  // Next state, latched burst context and the bank strobes (strobes follow wr_valid in the same cycle).
  always_comb begin
    state_d      = state_q;
    bank_d       = Sel_Mem;
    addr_d       = Address;
    beat_d       = beat_q;
    len_d        = len_q;
    Eneable      = 1'b0;
    WriteEneable = 1'b1;
    Data         = '0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          bank_d  = req_bank;
          addr_d  = req_addr;
          len_d   = req_len;
          beat_d  = '0;
          state_d = over_c ? S_ERR : (req_write ? S_WR : S_RD_ISSUE);
        end
      end
      S_WR: begin
        if (wr_valid) begin
          Eneable      = 1'b1;
          WriteEneable = 1'b0;
          Data         = wr_data;
          addr_d       = Address + ADDR_W'(1);
          beat_d       = beat_q + LEN_W'(1);
          if (beat_q == len_q) state_d = S_DONE;
        end
      end
      S_RD_ISSUE: begin
        Eneable = 1'b1;
        state_d = S_RD_CAP;
      end
      S_RD_CAP: state_d = S_RD_HOLD;
      S_RD_HOLD: begin
        if (rd_ready) begin
          if (beat_q == len_q) begin
            state_d = S_DONE;
          end else begin
            addr_d  = Address + ADDR_W'(1);
            beat_d  = beat_q + LEN_W'(1);
            state_d = S_RD_ISSUE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bank_access_ctrl.sv
// Randomized bench for bank_access_ctrl: bank memory model, bus monitor and a burst-level reference memory.
`timescale 1ns/1ps
module tb_bank_access_ctrl;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned LEN_W  = 3;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
`ifdef BANK_ACCESS_CTRL_BOUNDARY_CHECK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif

  logic CLK = 1'b0, RSTn;
  logic req_valid, req_ready, req_write;
  logic [1:0] req_bank;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0] req_len;
  logic [DATA_W-1:0] wr_data, rd_data, Data;
  logic wr_valid, wr_ready, rd_valid, rd_ready, done, err;
  logic [1:0] Sel_Mem;
  logic Eneable, WriteEneable;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] LineData = '0;

  bank_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .CLK(CLK), .RSTn(RSTn), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_bank(req_bank), .req_addr(req_addr), .req_len(req_len), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .done(done), .err(err), .Sel_Mem(Sel_Mem), .Eneable(Eneable),
    .Address(Address), .Data(Data), .WriteEneable(WriteEneable), .LineData(LineData));

  always #5 CLK = ~CLK;

  // Physical banks (environment) and the reference image of what bursts should have stored.
  logic [DATA_W-1:0] mem     [4][DEPTH] = '{default: '0};
  logic [DATA_W-1:0] ref_mem [4][DEPTH] = '{default: '0};

  always @(posedge CLK) begin
    if (Eneable && !WriteEneable) mem[Sel_Mem][Address] <= Data;
    if (Eneable && WriteEneable)  LineData <= mem[Sel_Mem][Address];
  end

  typedef logic [76:0] acc_t;
  acc_t wq[$], rq[$];
  int done_cnt = 0, err_cnt = 0, exp_err = 0;
  int nchk = 0, nbad = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    nchk++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bus monitor, sampled mid-cycle.
  always @(negedge CLK) begin
    if (RSTn) begin
      if (Eneable && !WriteEneable) wq.push_back({Sel_Mem, Address, Data});
      else if (Eneable)             rq.push_back({Sel_Mem, Address, 64'd0});
      else check("idle_bus", 96'({WriteEneable, Data}), 96'({1'b1, 64'd0}));
      if (done) done_cnt++;
      if (err)  err_cnt++;
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic issue(input bit w, input logic [1:0] b, input logic [ADDR_W-1:0] a,
                       input logic [LEN_W-1:0] l, output bit ok);
    int n = 0;
    req_write = w; req_bank = b; req_addr = a; req_len = l; req_valid = 1'b1;
    @(negedge CLK);
    while (!req_ready && n < 20) begin @(negedge CLK); n++; end
    ok = req_ready;
    check("req_ready", 96'(req_ready), 96'(1));
    tick();
    req_valid = 1'b0;
    req_write = 1'($urandom); req_bank = 2'($urandom); req_addr = ADDR_W'($urandom); req_len = LEN_W'($urandom);
  endtask

  task automatic wait_done(input int old, input string tag);
    int n = 0;
    while (done_cnt == old && n < 12) begin tick(); n++; end
    repeat (3) tick();
    check({tag, "_done_once"}, 96'(done_cnt - old), 96'(1));
  endtask

  task automatic do_write(input logic [1:0] b, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l,
                          input int gmin, input int gmax, input logic [DATA_W-1:0] base);
    bit ok, over;
    int d0, e0, n;
    logic [DATA_W-1:0] dat [8];
    d0 = done_cnt; e0 = err_cnt;
    over = BCHK && (int'(a) + int'(l) > int'(DEPTH) - 1);
    wq.delete(); rq.delete();
    issue(1'b1, b, a, l, ok);
    if (!ok) return;
    if (over) begin
      exp_err++;
      wait_done(d0, "wr_err");
      check("wr_err_pulse", 96'(err_cnt - e0), 96'(1));
      check("wr_err_noacc", 96'(wq.size() + rq.size()), 96'(0));
      return;
    end
    for (int i = 0; i <= int'(l); i++) begin
      dat[i] = (base != 0) ? base + DATA_W'(i) : {$urandom, $urandom};
      req_valid = (i < int'(l));
      repeat ($urandom_range(gmax, gmin)) tick();
      wr_valid = 1'b1; wr_data = dat[i];
      n = 0;
      @(negedge CLK);
      while (!wr_ready && n < 20) begin @(negedge CLK); n++; end
      check("wr_ready", 96'(wr_ready), 96'(1));
      check("busy_req_ready", 96'(req_ready), 96'(0));
      tick();
      wr_valid = 1'b0; wr_data = {$urandom, $urandom};
    end
    req_valid = 1'b0;
    wait_done(d0, "wr");
    check("wr_beats", 96'(wq.size()), 96'(int'(l) + 1));
    check("wr_no_reads", 96'(rq.size()), 96'(0));
    for (int i = 0; i <= int'(l); i++) begin
      ref_mem[b][ADDR_W'(int'(a) + i)] = dat[i];
      if (i < wq.size())
        check("wr_access", 96'(wq[i]), 96'({b, ADDR_W'(int'(a) + i), dat[i]}));
    end
  endtask

  task automatic do_read(input logic [1:0] b, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l,
                         input bit hold, input int smin, input int smax);
    bit ok, over;
    int d0, e0, n, s;
    logic [DATA_W-1:0] cap;
    d0 = done_cnt; e0 = err_cnt;
    over = BCHK && (int'(a) + int'(l) > int'(DEPTH) - 1);
    wq.delete(); rq.delete();
    rd_ready = hold;
    issue(1'b0, b, a, l, ok);
    if (!ok) begin rd_ready = 1'b0; return; end
    if (over) begin
      exp_err++;
      wait_done(d0, "rd_err");
      check("rd_err_pulse", 96'(err_cnt - e0), 96'(1));
      check("rd_err_noacc", 96'(wq.size() + rq.size()), 96'(0));
      rd_ready = 1'b0;
      return;
    end
    for (int i = 0; i <= int'(l); i++) begin
      n = 0;
      do begin @(negedge CLK); n++; end while (!rd_valid && n < 12);
      check("rd_valid", 96'(rd_valid), 96'(1));
      if (i == 0) check("rd_latency", 96'(n), 96'(3));
      cap = rd_data;
      check("rd_data", 96'(cap), 96'(ref_mem[b][ADDR_W'(int'(a) + i)]));
      if (hold) begin
        tick();
      end else begin
        s = $urandom_range(smax, smin);
        for (int k = 0; k < s; k++) begin
          tick();
          check("rd_stall_stable", 96'({rd_valid, rd_data}), 96'({1'b1, cap}));
          check("rd_stall_noacc", 96'(rq.size()), 96'(i + 1));
        end
        tick(); rd_ready = 1'b1;
        tick(); rd_ready = 1'b0;
      end
    end
    rd_ready = 1'b0;
    wait_done(d0, "rd");
    check("rd_accesses", 96'(rq.size()), 96'(int'(l) + 1));
    check("rd_no_writes", 96'(wq.size()), 96'(0));
    for (int i = 0; i <= int'(l) && i < rq.size(); i++)
      check("rd_access", 96'(rq[i]), 96'({b, ADDR_W'(int'(a) + i), 64'd0}));
  endtask

  task automatic reset_mid_write();
    bit ok;
    int d0;
    logic [DATA_W-1:0] dat [4];
    d0 = done_cnt;
    wq.delete(); rq.delete();
    issue(1'b1, 2'd1, 11'h100, 3'd3, ok);
    for (int i = 0; i < 4; i++) dat[i] = {$urandom, $urandom};
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1; wr_data = dat[i];
      tick();
    end
    wr_valid = 1'b1; wr_data = dat[2];
    #2 RSTn = 1'b0;
    #1;
    check("rst_en", 96'({Eneable, WriteEneable}), 96'({1'b0, 1'b1}));
    check("rst_bus", 96'({Sel_Mem, Address, Data}), 96'(0));
    check("rst_flags", 96'({req_ready, rd_valid, done, err}), 96'(0));
    wr_valid = 1'b0;
    tick();
    #2 RSTn = 1'b1;
    repeat (6) tick();
    check("rst_no_done", 96'(done_cnt - d0), 96'(0));
    check("rst_beats", 96'(wq.size()), 96'(2));
    for (int i = 0; i < 2; i++) begin
      ref_mem[1][ADDR_W'(11'h100 + i)] = dat[i];
      if (i < wq.size()) check("rst_access", 96'(wq[i]), 96'({2'd1, ADDR_W'(11'h100 + i), dat[i]}));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] a;
    RSTn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_bank = '0; req_addr = '0; req_len = '0;
    wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
    repeat (3) tick();
    check("reset_en", 96'({Eneable, WriteEneable}), 96'({1'b0, 1'b1}));
    check("reset_bus", 96'({Sel_Mem, Address, Data}), 96'(0));
    check("reset_flags", 96'({req_ready, wr_ready, rd_valid, done, err}), 96'(0));
    check("reset_rd_data", 96'(rd_data), 96'(0));
    #2 RSTn = 1'b1;
    tick();

    do_write(2'd2, 11'h010, 3'd3, 0, 0, 64'hA0);
    do_read(2'd2, 11'h010, 3'd3, 1'b1, 0, 0);
    do_read(2'd2, 11'h010, 3'd1, 1'b0, 5, 5);
    do_write(2'd0, 11'h7FF, 3'd1, 0, 0, 64'h0);
    do_read(2'd0, 11'h7FF, 3'd1, 1'b1, 0, 0);
    do_read(2'd0, 11'h000, 3'd0, 1'b1, 0, 0);
    do_write(2'd3, 11'h200, 3'd3, 2, 2, 64'h0);
    reset_mid_write();
    do_read(2'd1, 11'h100, 3'd3, 1'b1, 0, 0);
    do_write(2'd1, 11'h104, 3'd2, 0, 1, 64'h0);

    for (int t = 0; t < 40; t++) begin
      a = ($urandom_range(3, 0) == 0) ? ADDR_W'(11'h7FA + $urandom_range(5, 0)) : ADDR_W'($urandom_range(63, 0));
      if ($urandom_range(1, 0) == 1)
        do_write(2'($urandom), a, LEN_W'($urandom), 0, 2, 64'h0);
      else
        do_read(2'($urandom), a, LEN_W'($urandom), 1'($urandom), 0, 2);
    end

    check("err_total", 96'(err_cnt), 96'(exp_err));
    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule
